npn_canon_search: RTL

Sequential NPN canonicaliser for single-output Boolean functions of up to four inputs. It accepts a truth table, searches every input permutation, input negation mask and output negation one candidate per clock, and returns the numerically smallest transformed truth table together with the transform that produces it. It sits ahead of the exact-synthesis AIG library lookup, so that each NPN class is stored and matched once.

---
 rtl/npn_pkg.sv | 61 ++++++
 rtl/npn_tt_transform.sv | 29 ++
 rtl/npn_canon_search.sv | 132 +++++++++++++
 3 files changed

// File: rtl/npn_pkg.sv
// Shared types and permutation tables for the NPN canonicaliser.
// Permutation entries pack perm[k] into bits [2k+1:2k].
package npn_pkg;

    localparam int PERM_W   = 5;
    localparam int MAX_VARS = 4;

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} npn_state_e;

    typedef logic [23:0][7:0] perm_tab_t;

    // Lexicographic permutations of {0,1,2,3}; entry 18 is (3,0,1,2).
    localparam logic [7:0] PERM4_ROM [24] = '{
        8'hE4, 8'hB4, 8'hD8, 8'h78, 8'h9C, 8'h6C,
        8'hE1, 8'hB1, 8'hC9, 8'h39, 8'h8D, 8'h2D,
        8'hD2, 8'h72, 8'hC6, 8'h36, 8'h4E, 8'h1E,
        8'h93, 8'h63, 8'h87, 8'h27, 8'h4B, 8'h1B
    };

    function automatic int fact(input int n);
        int r;
        r = 1;
        for (int i = 2; i <= n; i++) r = r * i;
        return r;
    endfunction

    // Smaller N decode p through the factorial number system.
    function automatic perm_tab_t perm_table(input int n);
        perm_tab_t tab;
        int        used [4];
        int        r;
        int        idx;
        int        sel;
        int        f;
        tab = '0;
        for (int p = 0; p < fact(n); p++) begin
            if (n == 4) begin
                tab[p] = PERM4_ROM[p];
            end else begin
                for (int k = 0; k < 4; k++) used[k] = 0;
                r = p;
                for (int pos = 0; pos < n; pos++) begin
                    f   = fact(n - 1 - pos);
                    idx = r / f;
                    r   = r % f;
                    sel = 0;
                    for (int v = 0; v < n; v++) begin
                        if (used[v] == 0) begin
                            if (idx == 0) sel = v;
                            idx--;
                        end
                    end
                    used[sel] = 1;
                    tab[p][2*pos +: 2] = 2'(sel);
                end
            end
        end
        return tab;
    endfunction

endpackage

// File: rtl/npn_tt_transform.sv
// Combinational NPN transform: g[j] = o ^ f[i], i[k] = j[perm[k]] ^ m[k].
module npn_tt_transform #(
    parameter int NUM_VARS = 4,
    parameter int TT_W     = 2**NUM_VARS
) (
    input  logic [TT_W-1:0]     f_i,
    input  logic [7:0]          perm_i,
    input  logic [NUM_VARS-1:0] mask_i,
    input  logic                neg_i,
    output logic [TT_W-1:0]     g_o
);

    logic [NUM_VARS-1:0] jv;
    logic [NUM_VARS-1:0] iv;

    always_comb begin
        g_o = '0;
        jv  = '0;
        iv  = '0;
        for (int j = 0; j < TT_W; j++) begin
            jv = NUM_VARS'(j);
            for (int k = 0; k < NUM_VARS; k++) begin
                iv[k] = jv[perm_i[2*k +: 2]] ^ mask_i[k];
            end
            g_o[j] = neg_i ^ f_i[iv];
        end
    end

endmodule

// File: rtl/npn_canon_search.sv
// Sequential NPN canonicaliser: walks every (perm, mask, neg) candidate one per
// clock and keeps the first numerically smallest transformed truth table.
module npn_canon_search
    import npn_pkg::*;
#(
    parameter int NUM_VARS = 4,
    parameter int TT_W     = 2**NUM_VARS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [TT_W-1:0]     in_tt,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [TT_W-1:0]     out_tt,
    output logic [PERM_W-1:0]   out_perm,
    output logic [NUM_VARS-1:0] out_neg_mask,
    output logic                out_neg,
    output npn_state_e          dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    localparam int                NF     = fact(NUM_VARS);
    localparam perm_tab_t         PTAB   = perm_table(NUM_VARS);
    localparam logic [PERM_W-1:0] P_LAST = PERM_W'(NF - 1);

    npn_state_e          state_q, state_d;
    logic [TT_W-1:0]     f_q, f_d;
    logic [PERM_W-1:0]   p_q, p_d;
    logic [NUM_VARS-1:0] m_q, m_d;
    logic                o_q, o_d;
    logic [TT_W-1:0]     best_tt_q, best_tt_d;
    logic [PERM_W-1:0]   best_p_q, best_p_d;
    logic [NUM_VARS-1:0] best_m_q, best_m_d;
    logic                best_o_q, best_o_d;

    logic [TT_W-1:0]     cand_tt;
    logic                cand_first;
    logic                cand_last;

    npn_tt_transform #(.NUM_VARS(NUM_VARS), .TT_W(TT_W)) u_xform (
        .f_i    (f_q),
        .perm_i (PTAB[p_q]),
        .mask_i (m_q),
        .neg_i  (o_q),
        .g_o    (cand_tt)
    );

    assign cand_first = (p_q == '0) && (m_q == '0) && !o_q;
    assign cand_last  = (p_q == P_LAST) && (&m_q) && o_q;

    always_comb begin
        state_d   = state_q;
        f_d       = f_q;
        p_d       = p_q;
        m_d       = m_q;
        o_d       = o_q;
        best_tt_d = best_tt_q;
        best_p_d  = best_p_q;
        best_m_d  = best_m_q;
        best_o_d  = best_o_q;
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    f_d     = in_tt;
                    p_d     = '0;
                    m_d     = '0;
                    o_d     = 1'b0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                // Candidate 0 seeds the best register; later ones must be strictly smaller.
                if (cand_first || (cand_tt < best_tt_q)) begin
                    best_tt_d = cand_tt;
                    best_p_d  = p_q;
                    best_m_d  = m_q;
                    best_o_d  = o_q;
                end
                o_d = ~o_q;
                if (o_q) begin
                    m_d = m_q + 1'b1;
                    if (&m_q) p_d = p_q + 1'b1;
                end
                if (cand_last) begin
                    p_d     = '0;
                    m_d     = '0;
                    o_d     = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            f_q       <= '0;
            p_q       <= '0;
            m_q       <= '0;
            o_q       <= 1'b0;
            best_tt_q <= '0;
            best_p_q  <= '0;
            best_m_q  <= '0;
            best_o_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            f_q       <= f_d;
            p_q       <= p_d;
            m_q       <= m_d;
            o_q       <= o_d;
            best_tt_q <= best_tt_d;
            best_p_q  <= best_p_d;
            best_m_q  <= best_m_d;
            best_o_q  <= best_o_d;
        end
    end

    assign out_tt       = best_tt_q;
    assign out_perm     = best_p_q;
    assign out_neg_mask = best_m_q;
    assign out_neg      = best_o_q;
    assign dbg_state_o  = state_q;

endmodule
